// File: rtl/btn_pkg.sv
// Shared types and default layout for the on-screen button click detector.
package btn_pkg;

  localparam int BTN_COORD_W = 12;

  // Inclusive rectangle, x0 in the most significant field.
  typedef struct packed {
    logic [BTN_COORD_W-1:0] x0;
    logic [BTN_COORD_W-1:0] y0;
    logic [BTN_COORD_W-1:0] x1;
    logic [BTN_COORD_W-1:0] y1;
  } rect_t;

  typedef enum logic [1:0] {IDLE, ARMED, IGNORE, COOLDOWN} click_state_t;

  // Deal/hit/stand layout carried over from the fixed three-button detector.
  localparam rect_t DEAL_RECT  = '{x0: 12'd100, y0: 12'd500, x1: 12'd200, y1: 12'd540};
  localparam rect_t HIT_RECT   = '{x0: 12'd250, y0: 12'd500, x1: 12'd350, y1: 12'd540};
  localparam rect_t STAND_RECT = '{x0: 12'd400, y0: 12'd500, x1: 12'd500, y1: 12'd540};
  localparam logic [3*$bits(rect_t)-1:0] DEFAULT_RECTS = {STAND_RECT, HIT_RECT, DEAL_RECT};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_rect_hit.sv
// Inclusive rectangle hit test gated by the button enable (combinational).
// An inverted rectangle (x0>x1 or y0>y1) can never satisfy both bounds.
module btn_rect_hit
  import btn_pkg::*;
#(
  parameter int COORD_W = 12
) (
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [4*COORD_W-1:0] rect,
  input  logic                 en,
  output logic                 hit
);

  logic [COORD_W-1:0] x0, y0, x1, y1;

  assign x0 = rect[4*COORD_W-1:3*COORD_W];
  assign y0 = rect[3*COORD_W-1:2*COORD_W];
  assign x1 = rect[2*COORD_W-1:COORD_W];
  assign y1 = rect[COORD_W-1:0];

  assign hit = en && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);

endmodule

// File: rtl/button_click_ctrl.sv
// Registered click detector for N rectangular buttons.
// Optional feature macro: BTN_AUTOREPEAT_EN (repeat clicks while held on a button).
module button_click_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN          = 3,
  parameter int COORD_W        = 12,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int REPEAT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         mouse_x,
  input  logic [COORD_W-1:0]         mouse_y,
  input  logic                       left_mouse,
  input  logic [N_BTN-1:0]           btn_enable,
  input  logic [N_BTN*4*COORD_W-1:0] btn_rect,
  output logic [N_BTN-1:0]           click,
  output logic [N_BTN-1:0]           hover,
  output logic [N_BTN-1:0]           pressed,
  output logic                       busy
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CNT_W = $clog2(max_int(HOLDOFF_CYCLES, REPEAT_CYCLES) + 1);

  logic [COORD_W-1:0]         x_s1, y_s1;
  logic                       left_s1, v_s1;
  logic [N_BTN-1:0]           en_s1;
  logic [N_BTN*4*COORD_W-1:0] rect_s1;

  logic [N_BTN-1:0] hit_c;
  logic [N_BTN-1:0] en_s2;
  logic             left_s2, left_prev, v_s2;

  logic [IDX_W-1:0] hit_idx, idx;
  logic             press_rise;
  logic             arm_ok;
  logic [CNT_W-1:0] cnt;
  click_state_t     state;
`ifdef BTN_AUTOREPEAT_EN
  logic             fired;
`endif

  // S1: capture all inputs on the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s1    <= '0;
      y_s1    <= '0;
      left_s1 <= 1'b0;
      en_s1   <= '0;
      rect_s1 <= '0;
      v_s1    <= 1'b0;
    end else begin
      x_s1    <= mouse_x;
      y_s1    <= mouse_y;
      left_s1 <= left_mouse;
      en_s1   <= btn_enable;
      rect_s1 <= btn_rect;
      v_s1    <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_hit
    btn_rect_hit #(.COORD_W(COORD_W)) u_hit (
      .x    (x_s1),
      .y    (y_s1),
      .rect (rect_s1[i*4*COORD_W +: 4*COORD_W]),
      .en   (en_s1[i]),
      .hit  (hit_c[i])
    );
  end

  // S2: register hit vector and delay left button to match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hover     <= '0;
      en_s2     <= '0;
      left_s2   <= 1'b0;
      left_prev <= 1'b0;
      v_s2      <= 1'b0;
    end else begin
      hover     <= hit_c;
      en_s2     <= en_s1;
      left_s2   <= left_s1;
      left_prev <= left_s2;
      v_s2      <= v_s1;
    end
  end

  // Lowest-index hit wins when rectangles overlap
  always_comb begin
    hit_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (hover[i]) hit_idx = IDX_W'(i);
    end
  end

  // arm_ok blocks a false rising edge when reset releases with the button still held
  assign press_rise = arm_ok && left_s2 && !left_prev;

  // Click state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      arm_ok  <= 1'b0;
      click   <= '0;
      pressed <= '0;
      busy    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      fired   <= 1'b0;
`endif
    end else begin
      click <= '0;
      if (v_s2 && !left_s2) arm_ok <= 1'b1;
      case (state)
        IDLE: begin
          if (press_rise) begin
            busy <= 1'b1;
            if (|hover) begin
              state   <= ARMED;
              idx     <= hit_idx;
              pressed <= N_BTN'(1) << hit_idx;
`ifdef BTN_AUTOREPEAT_EN
              cnt     <= CNT_W'(1);
              fired   <= 1'b0;
`endif
            end else begin
              state <= IGNORE;
            end
          end
        end
        ARMED: begin
          if (!left_s2) begin
            pressed <= '0;
`ifdef BTN_AUTOREPEAT_EN
            if (fired) begin
              state <= COOLDOWN;
              cnt   <= CNT_W'(HOLDOFF_CYCLES - 1);
            end else
`endif
            if (hover[idx]) begin
              click <= N_BTN'(1) << idx;
              state <= COOLDOWN;
              cnt   <= CNT_W'(HOLDOFF_CYCLES - 1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (!en_s2[idx]) begin
            pressed <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (hover[idx]) begin
            if (cnt >= CNT_W'(REPEAT_CYCLES - 1)) begin
              click <= N_BTN'(1) << idx;
              cnt   <= '0;
              fired <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
`endif
        end
        IGNORE: begin
          if (!left_s2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_click_ctrl.sv
// Directed self-checking bench for button_click_ctrl.
module tb_button_click_ctrl;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP = 8;
`else
  localparam int REP = 1024;
`endif
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] mouse_x, mouse_y;
  logic         left_mouse;
  logic [2:0]   btn_enable;
  logic [3*4*W-1:0] btn_rect;
  logic [2:0]   click, hover, pressed;
  logic         busy;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_clicks = 0;
  logic [2:0]   click_or = '0;

  button_click_ctrl #(
    .N_BTN(3), .COORD_W(W), .HOLDOFF_CYCLES(16), .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .left_mouse (left_mouse),
    .btn_enable (btn_enable),
    .btn_rect   (btn_rect),
    .click      (click),
    .hover      (hover),
    .pressed    (pressed),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] mk_rect(input int x0, input int y0, input int x1, input int y1);
    return {W'(x0), W'(y0), W'(x1), W'(y1)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (click != 3'b000) begin
        n_clicks++;
        click_or |= click;
      end
    end
  endtask

  task automatic clr();
    n_clicks = 0;
    click_or = '0;
  endtask

  task automatic press_release(input int x, input int y, input int hold);
    mouse_x    = W'(x);
    mouse_y    = W'(y);
    left_mouse = 1'b1;
    tick(hold);
    left_mouse = 1'b0;
    tick(4);
  endtask

  initial begin
    rst        = 1'b1;
    left_mouse = 1'b0;
    mouse_x    = W'(150);
    mouse_y    = W'(520);
    btn_enable = 3'b111;
    btn_rect   = {mk_rect(400, 500, 500, 540), mk_rect(250, 500, 350, 540), mk_rect(100, 500, 200, 540)};
    tick(2);
    chk("reset_outputs", {click, hover, pressed, busy}, 32'h0);
    rst = 1'b0;
    tick(6);
    chk("hover_b0_idle", hover, 3'b001);

    // basic click with latency and cooldown length
    clr();
    left_mouse = 1'b1;
    tick(4);
    chk("pressed_b0", pressed, 3'b001);
    chk("busy_armed", busy, 1'b1);
    left_mouse = 1'b0;
    tick(1);
    chk("lat_edge_t", click, 3'b000);
    tick(1);
    chk("lat_edge_t1", click, 3'b000);
    tick(1);
    chk("lat_edge_t2", click, 3'b001);
    tick(1);
    chk("click_one_cycle", click, 3'b000);
    tick(14);
    chk("busy_cooldown_end", busy, 1'b1);
    tick(1);
    chk("busy_after_cooldown", busy, 1'b0);
    chk("basic_click_count", n_clicks, 1);

    // drag-off cancel
    clr();
    mouse_x    = W'(300);
    left_mouse = 1'b1;
    tick(4);
    chk("pressed_b1", pressed, 3'b010);
    mouse_x = W'(600);
    tick(4);
    chk("pressed_b1_dragged", pressed, 3'b010);
    left_mouse = 1'b0;
    tick(5);
    chk("drag_pressed_clear", pressed, 3'b000);
    chk("drag_idle", busy, 1'b0);
    chk("drag_no_click", n_clicks, 0);

    // press outside, release inside
    clr();
    mouse_x    = W'(50);
    mouse_y    = W'(50);
    left_mouse = 1'b1;
    tick(4);
    chk("ignore_busy", busy, 1'b1);
    chk("ignore_no_pressed", pressed, 3'b000);
    mouse_x = W'(150);
    mouse_y = W'(520);
    tick(4);
    chk("ignore_hover_b0", hover, 3'b001);
    left_mouse = 1'b0;
    tick(5);
    chk("ignore_no_click", n_clicks, 0);
    chk("ignore_idle", busy, 1'b0);

    // inclusive corners, just-outside, and press during cooldown
    clr();
    press_release(200, 540, 3);
    press_release(200, 540, 3);
    tick(25);
    chk("corner_hi_click", click_or, 3'b001);
    chk("cooldown_press_ignored", n_clicks, 1);
    clr();
    press_release(100, 500, 3);
    tick(20);
    chk("corner_lo_click", click_or, 3'b001);
    clr();
    press_release(201, 520, 3);
    tick(20);
    chk("outside_x_no_click", n_clicks, 0);
    clr();
    press_release(150, 499, 3);
    tick(20);
    chk("outside_y_no_click", n_clicks, 0);

    // overlap resolves to lowest index
    clr();
    btn_rect[1*4*W +: 4*W] = mk_rect(150, 500, 350, 540);
    press_release(175, 520, 3);
    tick(20);
    chk("overlap_low_idx", click_or, 3'b001);
    chk("overlap_count", n_clicks, 1);
    btn_rect[1*4*W +: 4*W] = mk_rect(250, 500, 350, 540);

    // inverted rectangle never hits
    clr();
    btn_rect[1*4*W +: 4*W] = mk_rect(350, 500, 250, 540);
    press_release(300, 520, 3);
    tick(20);
    chk("inverted_rect_no_click", n_clicks, 0);
    btn_rect[1*4*W +: 4*W] = mk_rect(250, 500, 350, 540);

    // disabled button and enable drop while held
    clr();
    btn_enable = 3'b110;
    mouse_x    = W'(150);
    mouse_y    = W'(520);
    tick(3);
    chk("disabled_hover", hover, 3'b000);
    press_release(150, 520, 3);
    tick(20);
    chk("disabled_no_click", n_clicks, 0);
    btn_enable = 3'b111;
    clr();
    mouse_x    = W'(450);
    left_mouse = 1'b1;
    tick(4);
    chk("pressed_b2", pressed, 3'b100);
    btn_enable = 3'b011;
    tick(4);
    chk("en_drop_pressed_clear", pressed, 3'b000);
    chk("en_drop_idle", busy, 1'b0);
    btn_enable = 3'b111;
    left_mouse = 1'b0;
    tick(6);
    chk("en_drop_no_click", n_clicks, 0);

    // reset while armed
    clr();
    mouse_x    = W'(150);
    left_mouse = 1'b1;
    tick(4);
    chk("pre_rst_pressed", pressed, 3'b001);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {click, hover, pressed, busy}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("rst_held_not_armed", {pressed, busy}, 32'h0);
    left_mouse = 1'b0;
    tick(6);
    chk("rst_release_no_click", n_clicks, 0);
    press_release(450, 520, 3);
    tick(20);
    chk("post_rst_click_b2", click_or, 3'b100);
    chk("post_rst_click_count", n_clicks, 1);

    // long hold on b0
    clr();
    mouse_x    = W'(150);
    left_mouse = 1'b1;
    tick(40);
    left_mouse = 1'b0;
    tick(25);
`ifdef BTN_AUTOREPEAT_EN
    chk("autorepeat_pulses", n_clicks, 5);
`else
    chk("long_hold_single_click", n_clicks, 1);
`endif
    chk("long_hold_b0", click_or, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
